// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing / test-pattern generator.
package vga_pkg;

   typedef enum logic [1:0] {
      VGA_GRID  = 2'd0,
      VGA_BARS  = 2'd1,
      VGA_CHECK = 2'd2,
      VGA_SOLID = 2'd3
   } vga_mode_e;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   localparam int unsigned VGA_HDISP  = 800;
   localparam int unsigned VGA_VDISP  = 480;
   localparam int unsigned VGA_HFP    = 40;
   localparam int unsigned VGA_HPULSE = 48;
   localparam int unsigned VGA_HBP    = 40;
   localparam int unsigned VGA_VFP    = 13;
   localparam int unsigned VGA_VPULSE = 3;
   localparam int unsigned VGA_VBP    = 29;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/video_if.sv
// Parallel video bus: pixel clock, syncs, active-display flag and 24-bit RGB.
interface video_if;
   logic        CLK;
   logic        HS;
   logic        VS;
   logic        BLANK;
   logic [23:0] RGB;

   modport master (output CLK, HS, VS, BLANK, RGB);
   modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_pattern.sv
// Combinational test-pattern colour lookup for one active pixel.
module vga_pattern
   import vga_pkg::*;
#(
   parameter int unsigned GRID_LOG2 = 4
) (
   input  vga_mode_e            mode,
   input  logic [2:0]           bar_idx,
   input  logic [GRID_LOG2:0]   xs,
   input  logic [GRID_LOG2:0]   y_lo,
   input  logic [23:0]          solid_rgb,
   output logic [23:0]          rgb
);

   always_comb begin
      rgb = '0;
      case (mode)
         VGA_GRID:  if (xs[GRID_LOG2-1:0] == '0 || y_lo[GRID_LOG2-1:0] == '0) rgb = '1;
         VGA_BARS:  rgb = bar_colour(bar_idx);
         VGA_CHECK: if (xs[GRID_LOG2] ^ y_lo[GRID_LOG2]) rgb = '1;
         VGA_SOLID: rgb = solid_rgb;
         default:   rgb = '0;
      endcase
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator. Optional horizontal scrolling of
// grid/checker patterns is enabled by defining VGA_PATGEN_SCROLL_EN.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned HDISP     = VGA_HDISP,
   parameter int unsigned VDISP     = VGA_VDISP,
   parameter int unsigned HFP       = VGA_HFP,
   parameter int unsigned HPULSE    = VGA_HPULSE,
   parameter int unsigned HBP       = VGA_HBP,
   parameter int unsigned VFP       = VGA_VFP,
   parameter int unsigned VPULSE    = VGA_VPULSE,
   parameter int unsigned VBP       = VGA_VBP,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned GRID_LOG2 = 4
) (
   input  logic                     pixel_clk,
   input  logic                     pixel_rst,
   input  logic [1:0]               mode,
   input  logic [23:0]              solid_rgb,
   video_if.master                  video_ifm,
   output logic [$clog2(HDISP)-1:0] x,
   output logic [$clog2(VDISP)-1:0] y,
   output logic                     sof,
   output logic [15:0]              frame_cnt
);

   localparam int unsigned HBLK   = HFP + HPULSE + HBP;
   localparam int unsigned VBLK   = VFP + VPULSE + VBP;
   localparam int unsigned HTOTAL = HDISP + HBLK;
   localparam int unsigned VTOTAL = VDISP + VBLK;
   localparam int unsigned HW     = $clog2(HTOTAL);
   localparam int unsigned VW     = $clog2(VTOTAL);
   localparam int unsigned XW     = $clog2(HDISP);
   localparam int unsigned YW     = $clog2(VDISP);
   localparam int unsigned BAR_W  = HDISP / 8;
   localparam int unsigned BW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int unsigned SW     = GRID_LOG2 + 1;

   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic [BW-1:0]  bar_px;
   logic [2:0]     bar_idx;
   vga_mode_e      mode_q;
   logic [23:0]    solid_q;
   logic           hs_q, vs_q, blank_q;
   logic [23:0]    rgb_q;

   logic           h_last, v_last, h_act, v_act, active, hs_win, vs_win;
   logic [XW-1:0]  x_c;
   logic [YW-1:0]  y_c;
   logic [SW-1:0]  xs;
   logic [23:0]    pat_rgb;

   assign h_last = (h_cnt == HW'(HTOTAL - 1));
   assign v_last = (v_cnt == VW'(VTOTAL - 1));
   assign h_act  = (h_cnt >= HW'(HBLK));
   assign v_act  = (v_cnt >= VW'(VBLK));
   assign active = h_act && v_act;
   assign hs_win = (h_cnt >= HW'(HFP)) && (h_cnt < HW'(HFP + HPULSE));
   assign vs_win = (v_cnt >= VW'(VFP)) && (v_cnt < VW'(VFP + VPULSE));
   assign x_c    = XW'(h_cnt - HW'(HBLK));
   assign y_c    = YW'(v_cnt - VW'(VBLK));

`ifdef VGA_PATGEN_SCROLL_EN
   logic [SW-1:0] scroll;

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst)           scroll <= '0;
      else if (h_last && v_last) scroll <= scroll + SW'(1);
   end

   assign xs = x_c[SW-1:0] + scroll;
`else
   assign xs = x_c[SW-1:0];
`endif

   vga_pattern #(.GRID_LOG2(GRID_LOG2)) u_pattern (
      .mode      (mode_q),
      .bar_idx   (bar_idx),
      .xs        (xs),
      .y_lo      (y_c[SW-1:0]),
      .solid_rgb (solid_q),
      .rgb       (pat_rgb)
   );

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         bar_px    <= '0;
         bar_idx   <= '0;
         mode_q    <= VGA_GRID;
         solid_q   <= '0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
         blank_q   <= 1'b0;
         rgb_q     <= '0;
         x         <= '0;
         y         <= '0;
         sof       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end

         // Bar counter is cleared through the blanking interval, so it is at
         // bar 0 on the first active pixel of every line without a divider.
         if (!h_act) begin
            bar_px  <= '0;
            bar_idx <= '0;
         end else if (bar_px == BW'(BAR_W - 1)) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_px  <= bar_px + BW'(1);
         end

         if (h_cnt == '0 && v_cnt == '0) begin
            mode_q  <= vga_mode_e'(mode);
            solid_q <= solid_rgb;
         end

         hs_q    <= hs_win ? HS_POL : ~HS_POL;
         vs_q    <= vs_win ? VS_POL : ~VS_POL;
         blank_q <= active;
         rgb_q   <= active ? pat_rgb : '0;
         sof     <= active && (x_c == '0) && (y_c == '0);
         if (active) begin
            x <= x_c;
            y <= y_c;
         end
         if (h_last && v_last) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign video_ifm.CLK   = pixel_clk;
   assign video_ifm.HS    = hs_q;
   assign video_ifm.VS    = vs_q;
   assign video_ifm.BLANK = blank_q;
   assign video_ifm.RGB   = rgb_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a 16x8 geometry (HTOTAL=24, VTOTAL=13).
module tb_vga_pattern_gen;

   localparam int HT = 24, VT = 13, FP = HT * VT;
   localparam int HB = 8, VB = 5;

   logic        pixel_clk = 1'b0;
   logic        pixel_rst = 1'b1;
   logic [1:0]  mode      = 2'd0;
   logic [23:0] solid_rgb = 24'h0;
   logic [3:0]  x;
   logic [2:0]  y;
   logic        sof;
   logic [15:0] frame_cnt;

   video_if vif ();

   vga_pattern_gen #(
      .HDISP(16), .VDISP(8), .HFP(2), .HPULSE(3), .HBP(3),
      .VFP(1), .VPULSE(2), .VBP(2), .HS_POL(1'b0), .VS_POL(1'b0), .GRID_LOG2(2)
   ) dut (
      .pixel_clk (pixel_clk),
      .pixel_rst (pixel_rst),
      .mode      (mode),
      .solid_rgb (solid_rgb),
      .video_ifm (vif),
      .x         (x),
      .y         (y),
      .sof       (sof),
      .frame_cnt (frame_cnt)
   );

   always #5 pixel_clk = ~pixel_clk;

   int          n_cmp = 0, n_fail = 0;
   int          k = 0;
   int          lx = 0, ly = 0;
   logic [1:0]  fmode = 2'd0;
   logic [23:0] fsolid = 24'h0;
   logic [23:0] bars [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s at k=%0d: got %h expected %h", nm, k, act, exp);
      end
   endtask

   function automatic logic [23:0] pix(input logic [1:0] m, input logic [23:0] sc,
                                       input int px, input int py, input int f);
      int xs;
`ifdef VGA_PATGEN_SCROLL_EN
      xs = (px + f) % 8;
`else
      xs = px + 0 * f;
`endif
      case (m)
         2'd0:    return ((xs % 4) == 0 || (py % 4) == 0) ? 24'hFFFFFF : 24'h0;
         2'd1:    return bars[px / 2];
         2'd2:    return (((xs / 4) % 2) != ((py / 4) % 2)) ? 24'hFFFFFF : 24'h0;
         default: return sc;
      endcase
   endfunction

   // Expected outputs follow directly from elapsed cycles since reset release.
   task automatic step();
      int s, h, v, f;
      logic act, e_hs, e_vs, e_sof;
      logic [23:0] e_rgb;
      @(posedge pixel_clk);
      #1;
      k++;
      s = k - 1; h = s % HT; v = (s / HT) % VT; f = s / FP;
      e_hs = !(h >= 2 && h < 5);
      e_vs = !(v >= 1 && v < 3);
      act  = (h >= HB) && (v >= VB);
      if (act) begin lx = h - HB; ly = v - VB; end
      e_rgb = act ? pix(fmode, fsolid, lx, ly, f) : 24'h0;
      e_sof = act && lx == 0 && ly == 0;
      check("sync", {28'd0, vif.HS, vif.VS, vif.BLANK, sof}, {28'd0, e_hs, e_vs, act, e_sof});
      check("coord", {25'd0, x, y}, 32'(lx * 8 + ly));
      check("rgb", {8'd0, vif.RGB}, {8'd0, e_rgb});
      check("frame_cnt", {16'd0, frame_cnt}, 32'((k / FP) % 65536));
      if (h == 0 && v == 0) begin fmode = mode; fsolid = solid_rgb; end
   endtask

   task automatic run_until(input int phase, input int budget);
      int n = 0;
      do begin step(); n++; end while (((k - 1) % FP) != phase && n < budget);
      if (((k - 1) % FP) != phase) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_phase: got %0d expected %0d", (k - 1) % FP, phase);
      end
   endtask

   task automatic check_reset(input string nm);
      check({nm, "_sync"}, {28'd0, vif.HS, vif.VS, vif.BLANK, sof}, 32'b1100);
      check({nm, "_xy"}, {25'd0, x, y}, 32'd0);
      check({nm, "_rgb"}, {8'd0, vif.RGB}, 32'd0);
      check({nm, "_frame"}, {16'd0, frame_cnt}, 32'd0);
   endtask

   task automatic release_and_find_sof(input string nm);
      int n = 0;
      @(negedge pixel_clk);
      pixel_rst = 1'b0;
      k = 0; lx = 0; ly = 0; fmode = 2'd0; fsolid = 24'h0;
      do begin step(); n++; end while (!vif.BLANK && n < 400);
      check({nm, "_first_blank"}, 32'(k), 32'd129);
      check({nm, "_first_sof"}, {31'd0, sof}, 32'd1);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [23:0] solid;
      int          x;
      int          y;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[$];
   logic [23:0] img [9][128];

   initial begin
      int hs_low, vs_low, run, max_run, c0, c1;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`ifndef VGA_PATGEN_SCROLL_EN
      tbl.push_back('{2'd0, 24'h0, 0, 0, 24'hFFFFFF});
      tbl.push_back('{2'd0, 24'h0, 5, 0, 24'hFFFFFF});
      tbl.push_back('{2'd0, 24'h0, 4, 1, 24'hFFFFFF});
      tbl.push_back('{2'd0, 24'h0, 5, 1, 24'h000000});
      tbl.push_back('{2'd0, 24'h0, 13, 4, 24'hFFFFFF});
      tbl.push_back('{2'd2, 24'h0, 0, 0, 24'h000000});
      tbl.push_back('{2'd2, 24'h0, 4, 0, 24'hFFFFFF});
      tbl.push_back('{2'd2, 24'h0, 5, 5, 24'h000000});
      tbl.push_back('{2'd2, 24'h0, 1, 6, 24'hFFFFFF});
`endif
      tbl.push_back('{2'd1, 24'h0, 1, 2, 24'hFFFFFF});
      tbl.push_back('{2'd1, 24'h0, 3, 2, 24'hFFFF00});
      tbl.push_back('{2'd1, 24'h0, 4, 3, 24'h00FFFF});
      tbl.push_back('{2'd1, 24'h0, 7, 0, 24'h00FF00});
      tbl.push_back('{2'd1, 24'h0, 9, 5, 24'hFF00FF});
      tbl.push_back('{2'd1, 24'h0, 10, 5, 24'hFF0000});
      tbl.push_back('{2'd1, 24'h0, 13, 7, 24'h0000FF});
      tbl.push_back('{2'd1, 24'h0, 15, 7, 24'h000000});
      tbl.push_back('{2'd3, 24'h123456, 6, 3, 24'h123456});
      tbl.push_back('{2'd3, 24'hABCDEF, 15, 0, 24'hABCDEF});

      repeat (3) @(negedge pixel_clk);
      check_reset("reset");
      release_and_find_sof("boot");

      hs_low = 0; vs_low = 0; run = 0; max_run = 0;
      for (int i = 0; i < FP; i++) begin
         step();
         if (!vif.HS) begin hs_low++; run++; if (run > max_run) max_run = run; end
         else run = 0;
         if (!vif.VS) vs_low++;
      end
      check("hs_low_per_frame", 32'(hs_low), 32'd39);
      check("hs_low_width", 32'(max_run), 32'd3);
      check("vs_low_per_frame", 32'(vs_low), 32'd48);

      foreach (tbl[i]) begin
         mode = tbl[i].mode;
         solid_rgb = tbl[i].solid;
         run_until(0, 2 * FP);
         run_until((VB + tbl[i].y) * HT + HB + tbl[i].x, FP);
         check("table_rgb", {8'd0, vif.RGB}, {8'd0, tbl[i].exp});
      end

      mode = 2'd0;
      run_until(0, 2 * FP);
      run_until(8 * HT, FP);
      mode = 2'd3; solid_rgb = 24'h123456;
      c0 = 0;
      for (int i = 0; i < FP; i++) begin
         step();
         if (vif.BLANK && vif.RGB == 24'h123456) c0++;
         if (((k - 1) % FP) == 0) break;
      end
      check("switch_cur_frame", 32'(c0), 32'd0);
      c1 = 0;
      for (int i = 0; i < FP; i++) begin
         step();
         if (vif.BLANK && vif.RGB == 24'h123456) c1++;
      end
      check("switch_next_frame", 32'(c1), 32'd128);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            mode = 2'($urandom_range(0, 3));
            solid_rgb = 24'($urandom);
         end
         step();
      end

`ifdef VGA_PATGEN_SCROLL_EN
      mode = 2'd2;
      run_until(0, 2 * FP);
      for (int fr = 0; fr < 9; fr++)
         for (int i = 0; i < FP; i++) begin
            step();
            if (vif.BLANK) img[fr][int'(y) * 16 + int'(x)] = vif.RGB;
         end
      for (int p = 0; p < 128; p++) begin
         check("scroll_shift", {8'd0, img[1][p]}, {8'd0, img[0][(p / 16) * 16 + (p % 16 + 1) % 16]});
         check("scroll_period", {8'd0, img[8][p]}, {8'd0, img[0][p]});
      end
`endif

      run_until(6 * HT + 10, 2 * FP);
      #2 pixel_rst = 1'b1;
      #1;
      check_reset("async_rst");
      @(negedge pixel_clk);
      check_reset("held_rst");
      release_and_find_sof("rerun");
      repeat (2 * FP) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
